// File: rtl/param_sp_ram_pkg.sv
// Shared types and helpers for the single-port RAM with init engine.
package param_sp_ram_pkg;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_e;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Storage with byte-enabled synchronous write and registered read.
// PARAM_SP_RAM_PARITY_EN adds one even-parity bit per stored byte.
module sp_ram_array
    import param_sp_ram_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DW-1:0]       wdata_i,
    input  logic [DW/8-1:0]     be_i,
    input  logic                re_i,
    input  logic                in_range_i,
    output logic                rd_valid_o,
    output logic [DW-1:0]       rd_data_o
`ifdef PARAM_SP_RAM_PARITY_EN
    ,
    output logic [DW/8-1:0]     rd_par_o
`endif
);

    localparam int NB = DW / 8;

    logic [DW-1:0] mem_q [DEPTH];
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;
`ifdef PARAM_SP_RAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] rd_par_q;
`endif

    // No reset on the array itself; the init engine provides the known state.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
`ifdef PARAM_SP_RAM_PARITY_EN
                    par_q[addr_i][b] <= byte_parity(wdata_i[8*b +: 8]);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef PARAM_SP_RAM_PARITY_EN
            rd_par_q   <= '0;
`endif
        end else begin
            rd_valid_q <= re_i;
            if (re_i) begin
                rd_data_q <= in_range_i ? mem_q[addr_i] : '0;
`ifdef PARAM_SP_RAM_PARITY_EN
                rd_par_q  <= in_range_i ? par_q[addr_i] : '0;
`endif
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
`ifdef PARAM_SP_RAM_PARITY_EN
    assign rd_par_o   = rd_par_q;
`endif

endmodule

// File: rtl/param_sp_ram.sv
// Single-port RAM with valid/ready request port and an init sweep after reset/clear.
// PARAM_SP_RAM_PARITY_EN enables per-byte parity storage and rd_perr reporting.
module param_sp_ram
    import param_sp_ram_pkg::*;
#(
    parameter int             DW       = 32,
    parameter int             DEPTH    = 64,
    parameter int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter logic [DW-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    input  logic [DW/8-1:0]   req_be,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic              rd_perr
);

    localparam int NB = DW / 8;

    state_e        state_q, state_d;
    logic [AW-1:0] init_ptr_q, init_ptr_d;

    logic          accept, in_range, in_init;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [NB-1:0] ram_be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            ST_INIT: begin
                init_ptr_d = init_ptr_q + AW'(1);
                if (init_ptr_q == AW'(DEPTH - 1)) begin
                    state_d    = ST_IDLE;
                    init_ptr_d = '0;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d    = ST_INIT;
                    init_ptr_d = '0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_ptr_d = '0;
            end
        endcase
    end

    assign in_init   = (state_q == ST_INIT);
    assign req_ready = (state_q == ST_IDLE);
    assign init_done = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_range  = (32'(req_addr) < DEPTH);

    // Init engine owns the port during INIT; requests are never accepted then.
    assign ram_we    = in_init | (accept & req_we & in_range);
    assign ram_re    = accept & ~req_we;
    assign ram_addr  = in_init ? init_ptr_q : req_addr;
    assign ram_wdata = in_init ? INIT_VAL   : req_wdata;
    assign ram_be    = in_init ? '1         : req_be;

`ifdef PARAM_SP_RAM_PARITY_EN
    logic [NB-1:0] rd_par;
    logic          par_mismatch;
`endif

    sp_ram_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (ram_we),
        .addr_i     (ram_addr),
        .wdata_i    (ram_wdata),
        .be_i       (ram_be),
        .re_i       (ram_re),
        .in_range_i (in_range),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data)
`ifdef PARAM_SP_RAM_PARITY_EN
        ,
        .rd_par_o   (rd_par)
`endif
    );

`ifdef PARAM_SP_RAM_PARITY_EN
    // Out-of-range reads return zero data with zero parity, so never mismatch.
    always_comb begin
        par_mismatch = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (byte_parity(rd_data[8*b +: 8]) != rd_par[b]) par_mismatch = 1'b1;
        end
    end
    assign rd_perr = rd_valid & par_mismatch;
`else
    assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_param_sp_ram.sv
// Scoreboard bench for param_sp_ram (DW=32, DEPTH=48, INIT_VAL=0).
module tb_param_sp_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_req;
    logic        init_done;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_perr;

    typedef struct {
        logic [31:0] d;
        logic        perr;
        int          due;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    param_sp_ram #(
        .DW       (32),
        .DEPTH    (48),
        .INIT_VAL (32'h0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .init_done (init_done),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_perr   (rd_perr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding read.
    exp_t e;
    always @(negedge clk) begin
        if (rd_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rd_valid: got rd_data=%h expected no pulse", rd_data);
            end else begin
                e = q.pop_front();
                check("rd_data", rd_data, e.d);
                check("rd_perr", 32'(rd_perr), 32'(e.perr));
                check("rd_latency_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic issue(input logic we, input int a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] ed, input logic ep);
        int w;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = 6'(a);
        req_wdata = d;
        req_be    = be;
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL req_ready_timeout: got 0 expected 1 (addr %0d)", a);
        end else if (!we) begin
            q.push_back('{ed, ep, cyc + 1});
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        issue(1'b1, a, d, be, 32'h0, 1'b0);
    endtask

    task automatic rd(input int a, input logic [31:0] ed, input logic ep);
        issue(1'b0, a, 32'h0, 4'h0, ed, ep);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts negedges with req_ready=0 starting at the current one.
    task automatic count_init(input string name, input int exp);
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(name, 32'(n), 32'(exp));
        check({name, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; clear_req = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_rd_valid",  32'(rd_valid),  32'd0);
        check("rst_rd_data",   rd_data,        32'h0);
        check("rst_rd_perr",   32'(rd_perr),   32'd0);

        // 1: hold a read of addr 0 pending through the whole sweep
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd0;
        @(negedge clk);
        rst_n = 1'b1;
        count_init("init_len_after_reset", 48);
        q.push_back('{32'h0, 1'b0, cyc + 1});
        for (int a = 1; a < 48; a++) rd(a, 32'h0, 1'b0);

        // 2: byte enables
        wr(5, 32'hDEADBEEF, 4'hF);
        wr(5, 32'h11223344, 4'b0101);
        rd(5, 32'hDE22BE44, 1'b0);
        wr(5, 32'h00000000, 4'h0);
        rd(5, 32'hDE22BE44, 1'b0);

        // 3: write then immediate read, then four back-to-back reads
        wr(7, 32'hA5A5A5A5, 4'hF);
        rd(7, 32'hA5A5A5A5, 1'b0);
        rd(5, 32'hDE22BE44, 1'b0);
        rd(7, 32'hA5A5A5A5, 1'b0);
        rd(0, 32'h0, 1'b0);
        rd(1, 32'h0, 1'b0);

        // 4: out-of-range write dropped, read returns zero
        wr(50, 32'hFFFFFFFF, 4'hF);
        rd(50, 32'h0, 1'b0);
        rd(2, 32'h0, 1'b0);
        rd(47, 32'h0, 1'b0);
        rd(5, 32'hDE22BE44, 1'b0);
        rd(7, 32'hA5A5A5A5, 1'b0);

        // 5: fill, clear with a same-cycle read, then sweep
        for (int a = 0; a < 48; a++) wr(a, 32'hC0DE0000 + 32'(a), 4'hF);
        rd(47, 32'hC0DE002F, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd3; clear_req = 1'b1;
        check("clear_cycle_ready", 32'(req_ready), 32'd1);
        q.push_back('{32'hC0DE0003, 1'b0, cyc + 1});
        @(negedge clk);
        clear_req = 1'b0; req_valid = 1'b0;
        count_init("init_len_after_clear", 48);
        rd(0, 32'h0, 1'b0);
        rd(3, 32'h0, 1'b0);
        rd(24, 32'h0, 1'b0);
        rd(47, 32'h0, 1'b0);

        // reset at INIT cycle 20 restarts a full sweep
        wr(9, 32'h12345678, 4'hF);
        rd(9, 32'h12345678, 1'b0);
        idle();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midinit_rst_rd_data",  rd_data,        32'h0);
        check("midinit_rst_rd_valid", 32'(rd_valid),  32'd0);
        check("midinit_rst_ready",    32'(req_ready), 32'd0);
        check("midinit_rst_done",     32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_init("init_len_after_midreset", 48);
        rd(9, 32'h0, 1'b0);
        rd(46, 32'h0, 1'b0);

`ifdef PARAM_SP_RAM_PARITY_EN
        // 6: corrupt one stored parity bit of addr 3
        idle();
        dut.u_array.par_q[3][0] = ~dut.u_array.par_q[3][0];
        rd(3, 32'h0, 1'b1);
        rd(4, 32'h0, 1'b0);
        rd(50, 32'h0, 1'b0);
`endif

        idle();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        check("outstanding_reads", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
